// File: rtl/ps2_event_pkg.sv
// ps2_event_pkg: queued keyboard event layout and ps2_key bit positions
package ps2_event_pkg;
    localparam int TOG = 10;
    localparam int PRS = 9;
    localparam int EXT = 8;
    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } ps2_event_t;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: show-ahead FIFO with explicit occupancy count and clear priority
module event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic do_push;
    logic do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push & ~clr & (~full | pop);
    assign do_pop = pop & ~clr & ~empty;
    assign dout = empty ? '0 : mem[rptr];
    always_ff @(posedge clk_sys)
        if (do_push) mem[wptr] <= din;
    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= do_push ? wptr + AW'(1) : wptr;
            rptr <= do_pop ? rptr + AW'(1) : rptr;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: turns toggle-strobed ps2_key words into queued events with repeat filter and overflow flag
module ps2_event_fifo
    import ps2_event_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic                   rd,
    input  logic                   clr,
    output logic [9:0]             dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam bit SR = SUPPRESS_REPEAT != 0;
    logic armed;
    logic prev_tog;
    logic last_pressed;
    logic [8:0] last_key;
    logic ev;
    logic rep;
    logic accept;
    logic full;
    ps2_event_t ev_d;
    assign ev_d = '{pressed: ps2_key[PRS], extended: ps2_key[EXT], code: ps2_key[7:0]};
    assign ev = armed & (ps2_key[TOG] != prev_tog);
    assign rep = SR & ps2_key[PRS] & last_pressed & (last_key == ps2_key[8:0]);
    assign accept = ev & ~rep;
    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) begin
            armed <= 1'b0;
            prev_tog <= 1'b0;
            last_pressed <= 1'b0;
            last_key <= '0;
            overflow <= 1'b0;
        end else begin
            armed <= 1'b1;
            prev_tog <= ps2_key[TOG];
            if (clr) begin
                last_pressed <= 1'b0;
                overflow <= 1'b0;
            end else if (accept) begin
                last_pressed <= ps2_key[PRS];
                last_key <= ps2_key[8:0];
                if (full && !rd) overflow <= 1'b1;
            end
        end
    event_fifo #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .push(accept),
        .pop(rd),
        .clr(clr),
        .din(ev_d),
        .dout(dout),
        .count(count),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_ps2_event_fifo.sv
// tb_ps2_event_fifo: directed self-checking bench for ps2_event_fifo
module tb_ps2_event_fifo;
    logic clk_sys = 1'b0;
    logic reset_n;
    logic [10:0] ps2_key;
    logic rd;
    logic clr;
    logic [9:0] dout;
    logic empty;
    logic [4:0] count;
    logic overflow;
    logic [9:0] dout0;
    logic empty0;
    logic [4:0] count0;
    logic overflow0;
    int npass = 0;
    int ntotal = 0;

    always #5 clk_sys = ~clk_sys;

    ps2_event_fifo #(.DEPTH(16), .SUPPRESS_REPEAT(1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .rd(rd), .clr(clr),
        .dout(dout), .empty(empty), .count(count), .overflow(overflow)
    );
    ps2_event_fifo #(.DEPTH(16), .SUPPRESS_REPEAT(0)) dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .rd(rd), .clr(clr),
        .dout(dout0), .empty(empty0), .count(count0), .overflow(overflow0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic p, input logic e, input logic [7:0] c);
        ps2_key = {~ps2_key[10], p, e, c};
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ps2_key = 11'h400;
        rd = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dout", dout, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("arm_empty", empty, 1);
            chk("arm_count", count, 0);
        end
        send(1'b1, 1'b0, 8'h1C);
        chk("single_empty", empty, 0);
        chk("single_count", count, 1);
        chk("single_dout", dout, 10'h21C);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("single_pop_empty", empty, 1);
        chk("single_pop_dout", dout, 0);
        do_clr();
        send(1'b1, 1'b0, 8'h1C);
        send(1'b1, 1'b0, 8'h1C);
        send(1'b1, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h1C);
        chk("rep_count", count, 2);
        chk("rep_count_nofilter", count0, 4);
        chk("rep_head0", dout, 10'h21C);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("rep_head1", dout, 10'h01C);
        do_clr();
        for (int i = 0; i < 17; i++) send(1'b1, 1'b0, 8'h20 + 8'(i));
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", dout, 10'h220);
        rd = 1'b1;
        send(1'b1, 1'b0, 8'h40);
        rd = 1'b0;
        chk("ovf_rdpush_count", count, 16);
        chk("ovf_rdpush_head", dout, 10'h221);
        chk("ovf_rdpush_flag", overflow, 1);
        rd = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        rd = 1'b0;
        chk("pre_clr_count", count, 5);
        chk("pre_clr_head", dout, 10'h22C);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h61};
        clr = 1'b1;
        rd = 1'b1;
        tick();
        clr = 1'b0;
        rd = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_overflow", overflow, 0);
        chk("clr_empty", empty, 1);
        tick();
        chk("clr_event_lost", count, 0);
        send(1'b1, 1'b0, 8'h40);
        chk("clr_filter_count", count, 1);
        chk("clr_filter_dout", dout, 10'h240);
        do_clr();
        send(1'b1, 1'b0, 8'h80);
        for (int i = 1; i <= 40; i++) begin
            rd = 1'b1;
            send(1'b1, 1'b0, 8'h80 + 8'(i));
            chk("wrap_count", count, 1);
            chk("wrap_dout", dout, {2'b10, 8'h80 + 8'(i)});
        end
        rd = 1'b0;
        send(1'b1, 1'b1, 8'h11);
        send(1'b0, 1'b1, 8'h11);
        chk("mid_count", count, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_empty", empty, 1);
        chk("async_count", count, 0);
        chk("async_overflow", overflow, 0);
        chk("async_dout", dout, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rearm_count", count, 0);
        send(1'b1, 1'b1, 8'h75);
        chk("rearm_event_count", count, 1);
        chk("rearm_event_dout", dout, 10'h375);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
